// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration register bank.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_cfg_pkg;

   // Frame sequencing: one R/W bit, then the address, then data words.
   typedef enum logic [1:0] {
      CMD  = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2
   } frame_state_t;

   // R/W bit encoding, first bit of every frame.
   localparam logic SPI_WR = 1'b0;
   localparam logic SPI_RD = 1'b1;

   // Address field width; a single-register bank still carries one address bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_cfg_frame.sv
// SPI frame decoder: R/W bit, address, data words; drives write strobes and read shifter.
// Latency: write commits on the edge of the last data bit; read data on sdo after the last address bit.
// Backpressure: none, the SPI master owns sclk and the block follows every edge.
//
// Ports:
//   sclk, rst_b        clock (rising edge) and async active-low reset
//   cs_b, sdi          chip select (active low, async frame clear) and serial data in
//   rd_data            register contents selected by rd_addr (from the register array)
//   sdo                serial read data, MSB first
//   wr_en/wr_addr/wr_data  single-edge write commit strobe
//   rd_load/rd_addr    output shifter reload request and the address it loads from
module spi_cfg_frame
   import spi_cfg_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int REG_W    = 8,
   parameter int ADDR_W   = 3
) (
   input  logic              sclk,
   input  logic              rst_b,
   input  logic              cs_b,
   input  logic              sdi,
   input  logic [REG_W-1:0]  rd_data,
   output logic              sdo,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [REG_W-1:0]  wr_data,
   output logic              rd_load,
   output logic [ADDR_W-1:0] rd_addr
);

   localparam int CNT_W = 6;

   frame_state_t      state_q, state_d;
   logic              rw_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic [REG_W-1:0]  shin_q;
   logic [REG_W-1:0]  shout_q;

   logic              frame_clr;
   logic              addr_last;
   logic              word_last;
   logic [ADDR_W-1:0] addr_shift;
   logic [ADDR_W-1:0] addr_inc;
   logic [REG_W-1:0]  shin_shift;

   // Deasserting chip select aborts the frame just like a reset does.
   assign frame_clr = ~rst_b | cs_b;

   // Shifter values including the bit arriving on this edge, so the last
   // address bit and the last data bit can be acted on in the same edge.
   assign addr_shift = ADDR_W'({addr_q, sdi});
   assign shin_shift = REG_W'({shin_q, sdi});

   // Burst increment wraps at the top of the bank rather than at 2^ADDR_W.
   assign addr_inc = (addr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : addr_q + ADDR_W'(1);

   assign addr_last = (state_q == ADDR) && (cnt_q == CNT_W'(ADDR_W - 1));
   assign word_last = (state_q == DATA) && (cnt_q == CNT_W'(REG_W - 1));

   assign wr_addr = addr_q;
   assign wr_data = shin_shift;
   assign sdo     = shout_q[REG_W-1];

   always_ff @(posedge sclk or posedge frame_clr) begin
      if (frame_clr) begin
         state_q <= CMD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      rd_load = 1'b0;
      rd_addr = addr_inc;
      case (state_q)
         CMD: begin
            state_d = ADDR;
         end
         ADDR: begin
            rd_addr = addr_shift;
            if (addr_last) begin
               state_d = DATA;
               rd_load = (rw_q == SPI_RD);
            end
         end
         DATA: begin
            // Next word of a burst is loaded from the incremented address.
            if (word_last) begin
               wr_en   = (rw_q == SPI_WR);
               rd_load = (rw_q == SPI_RD);
            end
         end
         default: begin
            state_d = CMD;
         end
      endcase
   end

   always_ff @(posedge sclk or posedge frame_clr) begin
      if (frame_clr) begin
         rw_q    <= SPI_WR;
         cnt_q   <= '0;
         addr_q  <= '0;
         shin_q  <= '0;
         shout_q <= '0;
      end else begin
         case (state_q)
            CMD: begin
               rw_q  <= sdi;
               cnt_q <= '0;
            end
            ADDR: begin
               addr_q <= addr_shift;
               cnt_q  <= addr_last ? '0 : cnt_q + CNT_W'(1);
               if (rd_load) begin
                  shout_q <= rd_data;
               end
            end
            DATA: begin
               shin_q <= word_last ? '0 : shin_shift;
               if (rd_load) begin
                  shout_q <= rd_data;
               end else begin
                  shout_q <= shout_q << 1;
               end
               if (word_last) begin
                  cnt_q  <= '0;
                  addr_q <= addr_inc;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               cnt_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/spi_cfg_regbank.sv
// SPI-programmable configuration register bank with a flattened cfg output.
// Latency: cfg updates on the sclk edge carrying the last bit of a written word.
// Backpressure: none, the SPI master owns sclk; chip select high aborts a frame.
//
// Ports:
//   sclk, rst_b   clock (rising edge) and async active-low reset
//   cs_b, sdi     chip select (active low) and serial data in, MSB first
//   sdo           serial read data, changes after rising sclk
//   cfg           register k at bits [k*REG_W +: REG_W]
module spi_cfg_regbank
   import spi_cfg_pkg::*;
#(
   parameter int NUM_REGS = 8,
   parameter int REG_W    = 8
) (
   input  logic                      sclk,
   input  logic                      rst_b,
   input  logic                      cs_b,
   input  logic                      sdi,
   output logic                      sdo,
   output logic [NUM_REGS*REG_W-1:0] cfg
);

   localparam int ADDR_W = addr_width(NUM_REGS);

   logic [REG_W-1:0]  regs_q [NUM_REGS];
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [REG_W-1:0]  wr_data;
   logic              rd_load;
   logic [ADDR_W-1:0] rd_addr;
   logic [REG_W-1:0]  rd_data;

   spi_cfg_frame #(
      .NUM_REGS (NUM_REGS),
      .REG_W    (REG_W),
      .ADDR_W   (ADDR_W)
   ) u_frame (
      .sclk    (sclk),
      .rst_b   (rst_b),
      .cs_b    (cs_b),
      .sdi     (sdi),
      .rd_data (rd_data),
      .sdo     (sdo),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_load (rd_load),
      .rd_addr (rd_addr)
   );

   // Storage survives chip-select toggling; only rst_b clears it.
   // Addresses past the end of the bank match no entry, so writes there drop.
   always_ff @(posedge sclk or negedge rst_b) begin
      if (!rst_b) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
      end else if (wr_en) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (wr_addr == ADDR_W'(k)) begin
               regs_q[k] <= wr_data;
            end
         end
      end
   end

   // Unmatched (out-of-range) read addresses fall through to zero.
   always_comb begin
      rd_data = '0;
      if (rd_load) begin
         for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_addr == ADDR_W'(k)) begin
               rd_data = regs_q[k];
            end
         end
      end
   end

   always_comb begin
      cfg = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         cfg[k*REG_W +: REG_W] = regs_q[k];
      end
   end

endmodule

// File: doc/spi_cfg_regbank.md
SPI_CFG_REGBANK -- requirements
Module: spi_cfg_regbank

Interface
REQ-001 Parameter NUM_REGS, default 8: number of configuration registers (1..256).
REQ-002 Parameter REG_W, default 8: width of each register in bits (1..32).
REQ-003 Localparam ADDR_W = max(1, clog2(NUM_REGS)): address field width.
REQ-004 sclk  input  1: the only clock; all sequential logic on rising edge.
REQ-005 rst_b  input  1: asynchronous, active-low reset.
REQ-006 cs_b  input  1: chip select, active low; high asynchronously clears frame state.
REQ-007 sdi  input  1: serial data in, MSB first, sampled on rising sclk.
REQ-008 sdo  output  1: serial read data, registered, changes after rising sclk; master samples on falling sclk.
REQ-009 cfg  output  NUM_REGS*REG_W: flattened register contents; register k occupies bits [k*REG_W +: REG_W].

Function
REQ-010 Frame SHALL be: 1 R/W bit (1 = read, 0 = write), then ADDR_W address bits, then one or more REG_W-bit data words, all MSB first.
REQ-011 Frame FSM states SHALL be CMD, ADDR, DATA; while cs_b is low it advances only on rising sclk.
REQ-012 CMD: the first edge captures R/W, then goes to ADDR with bit counter = 0.
REQ-013 ADDR: shifts in ADDR_W bits; on the edge of the last address bit, goes to DATA with counter = 0.
REQ-014 Read: on the last-address-bit edge the output shifter SHALL load reg[addr], so sdo = its MSB after that edge; each later edge shifts it left by one.
REQ-015 Write: data bits shift into an input shifter; on the edge of bit REG_W of a word, the full word SHALL be committed to reg[addr] on that same edge, and cfg updates after it.
REQ-016 Burst: after each completed word with cs_b still low, addr SHALL increment; NUM_REGS-1 wraps to 0. Reads load the next register on the completing edge.
REQ-017 addr >= NUM_REGS (non-power-of-2 NUM_REGS): writes SHALL be ignored; reads SHALL return all zeros.
REQ-018 cs_b high SHALL asynchronously clear FSM to CMD, clear counters, input/output shifters and addr, and force sdo to 0.
REQ-019 A partial word (cs_b rises before bit REG_W) SHALL be discarded with no register change.
REQ-020 Registers not addressed SHALL hold their value; cfg changes only on a write commit or on reset.
REQ-021 A read frame SHALL never modify any register.

Reset
REQ-022 rst_b low SHALL asynchronously clear all registers (cfg = 0), FSM to CMD, counters, shifters and addr to 0, and sdo to 0.
REQ-023 rst_b low mid-frame SHALL abort the frame; after rst_b rises, the next rising sclk with cs_b low is treated as a CMD bit, even if cs_b stays low throughout.
REQ-024 Frame logic async clear SHALL be (!rst_b | cs_b); register storage async clear SHALL be !rst_b only.

Structure
REQ-025 Shared package spi_cfg_pkg SHALL hold the FSM state enum (CMD, ADDR, DATA) and the R/W encoding constants (SPI_WR = 0, SPI_RD = 1).
REQ-026 One sub-module spi_cfg_frame SHALL hold the FSM, bit counter, addr and shifters, and emit wr_en, wr_addr, wr_data and rd_load.
REQ-027 The top level SHALL instantiate spi_cfg_frame and hold the register array and read mux.

Verification (NUM_REGS=8, REG_W=8, 12-bit frame)
REQ-028 Write 0xA5 to addr 3 (bits 0,011,10100101) -> cfg[31:24]=0xA5 after edge 12; all other bytes stay 0.
REQ-029 Read addr 3 after REQ-028 (1,011, then 8 dummy bits) -> sdo on falling edges 5..12 is 1,0,1,0,0,1,0,1; cfg unchanged.
REQ-030 Burst write at addr 7 with data 0x11, 0x22 in one cs_b low -> reg7=0x11, reg0=0x22 (wrap).
REQ-031 Write to addr 2, cs_b rises after 5 of 8 data bits -> reg2 unchanged; the next full frame decodes correctly from its CMD bit.
REQ-032 rst_b pulsed low mid-write with cs_b held low -> cfg=0, sdo=0; after release, a new write to addr 1 with 0x3C -> reg1=0x3C.
REQ-033 NUM_REGS=6: write to addr 7 -> no cfg change; read addr 6 -> sdo all zeros.
